// File: rtl/cooking_sequencer.sv
// -----------------------------------------------------------------------------
// cooking_sequencer
//   Microwave cooking-cycle controller: keypad time entry, start/pause/cancel,
//   door interlock, MM:SS BCD countdown, end-of-cycle beep and four recipe
//   presets that can be reprogrammed through the configuration key.
//
// Ports
//   clk      system clock (CLK_HZ cycles per second)
//   rst      synchronous, active-high reset
//   t        keypad levels: [9:0] digits, [10] start, [11] cancel
//   conf     configuration key level
//   r        recipe key levels
//   porta    door switch, 1 = open (level, not edge-detected)
//   disp     BCD digits {m1,m0,s1,s0}
//   luz      lamp enable
//   motor    turntable enable
//   aquec    magnetron enable
//   som      buzzer enable
//   ocupado  high while cooking, paused or beeping
// -----------------------------------------------------------------------------
module cooking_sequencer #(
  parameter int CLK_HZ = 1000,
  parameter int BEEP_S = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] t,
  input  logic        conf,
  input  logic [3:0]  r,
  input  logic        porta,
  output logic [15:0] disp,
  output logic        luz,
  output logic        motor,
  output logic        aquec,
  output logic        som,
  output logic        ocupado
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_S - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_COOK, S_PAUSE, S_DONE, S_CSEL, S_CENT
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE, EV_CANCEL, EV_START, EV_CONF, EV_RECIPE, EV_DIGIT
  } event_t;

  // Key sampling: *_q is the level registered at the last edge, *_prev the
  // level one edge earlier; a rise between them is acted on at the next edge.
  logic [11:0] t_q, t_prev;
  logic        conf_q, conf_prev;
  logic [3:0]  r_q, r_prev;

  logic [11:0] t_rise;
  logic        conf_rise;
  logic [3:0]  r_rise;

  assign t_rise    = t_q & ~t_prev;
  assign conf_rise = conf_q & ~conf_prev;
  assign r_rise    = r_q & ~r_prev;

  state_t        state, nxt_state;
  logic [15:0]   value, nxt_value;
  logic [2:0]    n, nxt_n;
  logic [PW-1:0] presc, nxt_presc;
  logic [BW-1:0] beep, nxt_beep;
  logic [1:0]    sel, nxt_sel;
  logic [15:0]   slot [4];
  logic          slot_we;
  logic [15:0]   slot_wdata;

  event_t      ev;
  logic [3:0]  ev_idx;
  logic        tick;
  logic [15:0] dec_value;

  // One-second decrement in BCD; seconds above 59 simply count down as
  // entered, and a seconds field of 00 borrows a whole minute as 59.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] o;
    o = v;
    if (v[3:0] != 4'd0) begin
      o[3:0] = v[3:0] - 4'd1;
    end else if (v[7:4] != 4'd0) begin
      o[7:4] = v[7:4] - 4'd1;
      o[3:0] = 4'd9;
    end else if (v[15:8] != 8'h00) begin
      o[7:0] = 8'h59;
      if (v[11:8] != 4'd0) begin
        o[11:8] = v[11:8] - 4'd1;
      end else begin
        o[15:12] = v[15:12] - 4'd1;
        o[11:8]  = 4'd9;
      end
    end
    return o;
  endfunction

  // The k-th digit typed lands in nibble k counting up from s0.
  function automatic logic [15:0] put_digit(input logic [15:0] v,
                                            input logic [1:0]  pos,
                                            input logic [3:0]  d);
    logic [15:0] o;
    o = v;
    o[{pos, 2'b00} +: 4] = d;
    return o;
  endfunction

  assign tick      = (presc == PRESC_MAX);
  assign dec_value = bcd_dec(value);

  // Single key event per cycle: cancel > start > conf > r[0..3] > digits.
  // The loops run from the highest index down so the lowest index wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    ev     = EV_NONE;
    ev_idx = '0;
    if (t_rise[11]) begin
      ev = EV_CANCEL;
    end else if (t_rise[10]) begin
      ev = EV_START;
    end else if (conf_rise) begin
      ev = EV_CONF;
    end else if (|r_rise) begin
      ev = EV_RECIPE;
      for (int i = 3; i >= 0; i--) if (r_rise[i]) ev_idx = 4'(i);
    end else if (|t_rise[9:0]) begin
      ev = EV_DIGIT;
      for (int i = 9; i >= 0; i--) if (t_rise[i]) ev_idx = 4'(i);
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_value  = value;
    nxt_n      = n;
    nxt_presc  = presc;
    nxt_beep   = beep;
    nxt_sel    = sel;
    slot_we    = 1'b0;
    slot_wdata = put_digit(value, n[1:0], ev_idx);
    case (state)
      S_IDLE: begin
        case (ev)
          EV_DIGIT: begin
            nxt_value = {12'h000, ev_idx};
            nxt_n     = 3'd1;
            nxt_state = S_ENTRY;
          end
          EV_RECIPE: begin
            nxt_value = slot[ev_idx[1:0]];
            nxt_n     = 3'd4;
            nxt_state = S_ENTRY;
          end
          EV_CONF: nxt_state = S_CSEL;
          default: ;
        endcase
      end
      S_ENTRY: begin
        case (ev)
          EV_CANCEL: begin
            nxt_value = '0;
            nxt_n     = '0;
            nxt_state = S_IDLE;
          end
          EV_START: begin
            if (!porta && value != 16'h0000) begin
              nxt_presc = '0;
              nxt_state = S_COOK;
            end
          end
          EV_RECIPE: begin
            nxt_value = slot[ev_idx[1:0]];
            nxt_n     = 3'd4;
          end
          EV_DIGIT: begin
            if (n < 3'd4) begin
              nxt_value = slot_wdata;
              nxt_n     = n + 3'd1;
            end
          end
          default: ;
        endcase
      end
      S_COOK: begin
        // Door and cancel both pre-empt a coinciding tick, so the held value
        // is the one before the decrement.
        if (ev == EV_CANCEL || porta) begin
          nxt_state = S_PAUSE;
        end else if (tick) begin
          nxt_presc = '0;
          nxt_value = dec_value;
          if (dec_value == 16'h0000) begin
            nxt_beep  = '0;
            nxt_n     = '0;
            nxt_state = S_DONE;
          end
        end else begin
          nxt_presc = presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (ev == EV_CANCEL) begin
          nxt_value = '0;
          nxt_n     = '0;
          nxt_state = S_IDLE;
        end else if (ev == EV_START && !porta) begin
          nxt_presc = '0;
          nxt_state = S_COOK;
        end
      end
      S_DONE: begin
        if (ev == EV_CANCEL) begin
          nxt_state = S_IDLE;
        end else if (tick) begin
          nxt_presc = '0;
          if (beep == BEEP_LAST) nxt_state = S_IDLE;
          else                   nxt_beep  = beep + BW'(1);
        end else begin
          nxt_presc = presc + PW'(1);
        end
      end
      S_CSEL: begin
        case (ev)
          EV_RECIPE: begin
            nxt_value = '0;
            nxt_n     = '0;
            nxt_sel   = ev_idx[1:0];
            nxt_state = S_CENT;
          end
          // A digit here belongs to the wall-clock block; just step aside.
          EV_DIGIT, EV_CANCEL, EV_CONF: nxt_state = S_IDLE;
          default: ;
        endcase
      end
      S_CENT: begin
        if (ev == EV_CANCEL) begin
          nxt_value = '0;
          nxt_n     = '0;
          nxt_state = S_IDLE;
        end else if (ev == EV_DIGIT) begin
          if (n == 3'd3) begin
            slot_we   = 1'b1;
            nxt_value = '0;
            nxt_n     = '0;
            nxt_state = S_IDLE;
          end else begin
            nxt_value = slot_wdata;
            nxt_n     = n + 3'd1;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state; the door is folded in from the current sample.
  always_ff @(posedge clk) begin
    // NOTE: state and output registers use non-blocking assignments so every
    // register here sees the pre-edge values of all others.
    if (rst) begin
      t_q       <= '0;
      t_prev    <= '0;
      conf_q    <= 1'b0;
      conf_prev <= 1'b0;
      r_q       <= '0;
      r_prev    <= '0;
      state     <= S_IDLE;
      value     <= '0;
      n         <= '0;
      presc     <= '0;
      beep      <= '0;
      sel       <= '0;
      // NOTE: the recipe slots are cleared by reset on purpose (presets return
      // to 0000), which keeps this small array in flops rather than a RAM.
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      disp      <= '0;
      luz       <= 1'b0;
      motor     <= 1'b0;
      aquec     <= 1'b0;
      som       <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      t_q       <= t;
      t_prev    <= t_q;
      conf_q    <= conf;
      conf_prev <= conf_q;
      r_q       <= r;
      r_prev    <= r_q;
      state     <= nxt_state;
      value     <= nxt_value;
      n         <= nxt_n;
      presc     <= nxt_presc;
      beep      <= nxt_beep;
      sel       <= nxt_sel;
      if (slot_we) slot[sel] <= slot_wdata;
      disp      <= (nxt_state == S_DONE) ? 16'h0000 : nxt_value;
      luz       <= porta | (nxt_state == S_COOK);
      motor     <= (nxt_state == S_COOK);
      aquec     <= (nxt_state == S_COOK);
      som       <= (nxt_state == S_DONE);
      ocupado   <= (nxt_state == S_COOK) || (nxt_state == S_PAUSE) ||
                   (nxt_state == S_DONE);
    end
  end

endmodule

// File: tb/tb_cooking_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cooking_sequencer
//   Self-checking bench for cooking_sequencer. A behavioural model, kept in
//   minutes/seconds integers and named modes, is stepped on every clock edge
//   by the stimulus side and pushes the expected outputs into a queue; a
//   separate monitor pops and compares once per cycle. Directed scenarios
//   also push hand-derived constant expectations into a second queue.
//   The DUT runs with a short second (CLK_HZ = 10) to keep runs brief.
// -----------------------------------------------------------------------------
module tb_cooking_sequencer;

  localparam int HZ    = 10;
  localparam int BEEPS = 3;

  logic        clk;
  logic        rst_in;
  logic [11:0] t_in;
  logic        conf_in;
  logic [3:0]  r_in;
  logic        porta_in;
  logic [15:0] disp;
  logic        luz, motor, aquec, som, ocupado;

  cooking_sequencer #(.CLK_HZ(HZ), .BEEP_S(BEEPS)) dut (
    .clk     (clk),
    .rst     (rst_in),
    .t       (t_in),
    .conf    (conf_in),
    .r       (r_in),
    .porta   (porta_in),
    .disp    (disp),
    .luz     (luz),
    .motor   (motor),
    .aquec   (aquec),
    .som     (som),
    .ocupado (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  typedef struct {
    string       name;
    logic [20:0] exp;
  } dchk_t;

  logic [20:0] cyc_q[$];
  dchk_t       dir_q[$];

  function automatic logic [20:0] vec(input logic [15:0] d, input logic l,
                                      input logic mo, input logic aq,
                                      input logic so, input logic oc);
    return {d, l, mo, aq, so, oc};
  endfunction

  task automatic check(input string name, input logic [20:0] act,
                       input logic [20:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got disp=%h luz,motor,aquec,som,ocupado=%b; want disp=%h flags=%b",
                  name, act[20:5], act[4:0], exp[20:5], exp[4:0]);
  endtask

  // Monitor: outputs are registered, so the value seen shortly after the
  // falling edge is the response to the preceding rising edge.
  always @(negedge clk) begin
    logic [20:0] act;
    dchk_t       d;
    #1;
    act = {disp, luz, motor, aquec, som, ocupado};
    if (cyc_q.size() > 0) begin
      cyc_no++;
      check($sformatf("cycle%0d", cyc_no), act, cyc_q.pop_front());
    end
    while (dir_q.size() > 0) begin
      d = dir_q.pop_front();
      check(d.name, act, d.exp);
    end
  end

  task automatic expect_now(input string name, input logic [20:0] e);
    dchk_t d;
    d.name = name;
    d.exp  = e;
    dir_q.push_back(d);
  endtask

  // ------------------------------------------------------ behavioural model
  typedef enum {M_IDLE, M_ENTRY, M_COOK, M_PAUSE, M_DONE, M_CSEL, M_CENT} mode_t;
  typedef enum {K_NONE, K_CANCEL, K_START, K_CONF, K_RECIPE, K_DIGIT} key_t;

  mode_t       m_mode;
  int          m_min, m_sec, m_n, m_sel, m_cnt, m_beeps;
  int          slot_min[4], slot_sec[4];
  logic        m_door;
  logic [11:0] lv_t, pend_t;
  logic        lv_conf, pend_conf;
  logic [3:0]  lv_r, pend_r;

  task automatic m_clear();
    m_min = 0;
    m_sec = 0;
    m_n   = 0;
  endtask

  // Typing order fills s0, s1, m0, m1.
  task automatic m_append(input int d);
    if (m_n < 4) begin
      case (m_n)
        0: m_sec = (m_sec / 10) * 10 + d;
        1: m_sec = d * 10 + (m_sec % 10);
        2: m_min = (m_min / 10) * 10 + d;
        default: m_min = d * 10 + (m_min % 10);
      endcase
      m_n++;
    end
  endtask

  task automatic m_load(input int i);
    m_min = slot_min[i];
    m_sec = slot_sec[i];
    m_n   = 4;
  endtask

  task automatic model_edge();
    key_t k;
    int   idx;
    if (rst_in) begin
      m_mode = M_IDLE;
      m_clear();
      m_sel = 0; m_cnt = 0; m_beeps = 0;
      for (int i = 0; i < 4; i++) begin slot_min[i] = 0; slot_sec[i] = 0; end
      lv_t = '0; pend_t = '0; lv_conf = 1'b0; pend_conf = 1'b0;
      lv_r = '0; pend_r = '0;
      m_door = 1'b0;
      return;
    end
    k = K_NONE;
    idx = 0;
    if (pend_t[11])      k = K_CANCEL;
    else if (pend_t[10]) k = K_START;
    else if (pend_conf)  k = K_CONF;
    else begin
      for (int i = 0; i < 4; i++)
        if (k == K_NONE && pend_r[i]) begin k = K_RECIPE; idx = i; end
      for (int i = 0; i < 10; i++)
        if (k == K_NONE && pend_t[i]) begin k = K_DIGIT; idx = i; end
    end
    pend_t = t_in & ~lv_t;       lv_t = t_in;
    pend_conf = conf_in & ~lv_conf; lv_conf = conf_in;
    pend_r = r_in & ~lv_r;       lv_r = r_in;
    m_door = porta_in;

    case (m_mode)
      M_IDLE: begin
        if (k == K_DIGIT) begin m_clear(); m_append(idx); m_mode = M_ENTRY; end
        else if (k == K_RECIPE) begin m_load(idx); m_mode = M_ENTRY; end
        else if (k == K_CONF) m_mode = M_CSEL;
      end
      M_ENTRY: begin
        if (k == K_CANCEL) begin m_clear(); m_mode = M_IDLE; end
        else if (k == K_START) begin
          if (!m_door && (m_min != 0 || m_sec != 0)) begin m_mode = M_COOK; m_cnt = 0; end
        end
        else if (k == K_RECIPE) m_load(idx);
        else if (k == K_DIGIT) m_append(idx);
      end
      M_COOK: begin
        if (k == K_CANCEL || m_door) m_mode = M_PAUSE;
        else begin
          m_cnt++;
          if (m_cnt == HZ) begin
            m_cnt = 0;
            if (m_sec > 0) m_sec--;
            else begin m_sec = 59; m_min--; end
            if (m_min == 0 && m_sec == 0) begin
              m_mode = M_DONE; m_beeps = 0; m_n = 0;
            end
          end
        end
      end
      M_PAUSE: begin
        if (k == K_CANCEL) begin m_clear(); m_mode = M_IDLE; end
        else if (k == K_START && !m_door) begin m_mode = M_COOK; m_cnt = 0; end
      end
      M_DONE: begin
        if (k == K_CANCEL) m_mode = M_IDLE;
        else begin
          m_cnt++;
          if (m_cnt == HZ) begin
            m_cnt = 0;
            m_beeps++;
            if (m_beeps == BEEPS) m_mode = M_IDLE;
          end
        end
      end
      M_CSEL: begin
        if (k == K_RECIPE) begin m_clear(); m_sel = idx; m_mode = M_CENT; end
        else if (k == K_DIGIT || k == K_CANCEL || k == K_CONF) m_mode = M_IDLE;
      end
      M_CENT: begin
        if (k == K_CANCEL) begin m_clear(); m_mode = M_IDLE; end
        else if (k == K_DIGIT) begin
          m_append(idx);
          if (m_n == 4) begin
            slot_min[m_sel] = m_min;
            slot_sec[m_sel] = m_sec;
            m_clear();
            m_mode = M_IDLE;
          end
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [20:0] model_outputs();
    logic [15:0] d;
    logic        cook;
    cook = (m_mode == M_COOK);
    if (m_mode == M_DONE) d = 16'h0000;
    else d = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    if (rst_in) return '0;
    return vec(d, m_door | cook, cook, cook, m_mode == M_DONE,
               cook || m_mode == M_PAUSE || m_mode == M_DONE);
  endfunction

  // --------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc_q.push_back(model_outputs());
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) step();
  endtask

  task automatic press_t(input int b);
    t_in[b] = 1'b1; step(); step(); t_in[b] = 1'b0; step();
  endtask

  task automatic press_r(input int b);
    r_in[b] = 1'b1; step(); step(); r_in[b] = 1'b0; step();
  endtask

  task automatic press_conf();
    conf_in = 1'b1; step(); step(); conf_in = 1'b0; step();
  endtask

  localparam int K_START_BIT  = 10;
  localparam int K_CANCEL_BIT = 11;

  int sel, kind, extra;

  initial begin
    rst_in = 1'b1; t_in = '0; conf_in = 1'b0; r_in = '0; porta_in = 1'b0;
    step(); step();
    rst_in = 1'b0;
    expect_now("reset_state", vec(16'h0000, 0, 0, 0, 0, 0));

    // 5,2,1 -> 01:25, cook to completion, beep, back to idle.
    press_t(5); press_t(2); press_t(1);
    expect_now("entry_0125", vec(16'h0125, 0, 0, 0, 0, 0));
    press_t(K_START_BIT);
    expect_now("cook_start_0125", vec(16'h0125, 1, 1, 1, 0, 1));
    wait_cycles(85 * HZ - 1);
    expect_now("done_after_85s", vec(16'h0000, 0, 0, 0, 1, 1));
    wait_cycles(BEEPS * HZ - 1);
    expect_now("beep_last_cycle", vec(16'h0000, 0, 0, 0, 1, 1));
    step();
    expect_now("idle_after_beep", vec(16'h0000, 0, 0, 0, 0, 0));

    // 6,7,4,1 -> 14:76, 30 s, pause, resume, 30 s, cancel twice.
    press_t(6); press_t(7); press_t(4); press_t(1);
    expect_now("entry_1476", vec(16'h1476, 0, 0, 0, 0, 0));
    press_t(K_START_BIT);
    wait_cycles(30 * HZ - 1);
    expect_now("cook_1446", vec(16'h1446, 1, 1, 1, 0, 1));
    press_t(K_CANCEL_BIT);
    expect_now("pause_1446", vec(16'h1446, 0, 0, 0, 0, 1));
    press_t(K_START_BIT);
    expect_now("resume_1446", vec(16'h1446, 1, 1, 1, 0, 1));
    wait_cycles(30 * HZ - 1);
    expect_now("cook_1416", vec(16'h1416, 1, 1, 1, 0, 1));
    press_t(K_CANCEL_BIT);
    press_t(K_CANCEL_BIT);
    expect_now("cancel_cancel_idle", vec(16'h0000, 0, 0, 0, 0, 0));

    // Program slot 2 with 03:49 and cook it across a minute boundary.
    press_conf(); press_r(2);
    press_t(9); press_t(4); press_t(3); press_t(0);
    expect_now("slot_written_idle", vec(16'h0000, 0, 0, 0, 0, 0));
    press_r(2);
    expect_now("recipe2_loaded", vec(16'h0349, 0, 0, 0, 0, 0));
    press_t(K_START_BIT);
    wait_cycles(HZ - 1);
    expect_now("cook_0348", vec(16'h0348, 1, 1, 1, 0, 1));
    wait_cycles(48 * HZ);
    expect_now("cook_0300", vec(16'h0300, 1, 1, 1, 0, 1));
    wait_cycles(HZ);
    expect_now("cook_0259", vec(16'h0259, 1, 1, 1, 0, 1));
    press_t(K_CANCEL_BIT); press_t(K_CANCEL_BIT);

    // Door opened mid-cook at 00:10.
    press_t(0); press_t(1);
    press_t(K_START_BIT);
    porta_in = 1'b1; step();
    expect_now("door_open_pause", vec(16'h0010, 1, 0, 0, 0, 1));
    press_t(K_START_BIT);
    expect_now("start_door_open_ignored", vec(16'h0010, 1, 0, 0, 0, 1));
    porta_in = 1'b0; step();
    expect_now("door_closed_lamp_off", vec(16'h0010, 0, 0, 0, 0, 1));
    press_t(K_START_BIT);
    expect_now("door_resume", vec(16'h0010, 1, 1, 1, 0, 1));
    press_t(K_CANCEL_BIT); press_t(K_CANCEL_BIT);

    // Start and digit 3 rise together: start wins, digit dropped.
    press_t(5);
    t_in[K_START_BIT] = 1'b1; t_in[3] = 1'b1;
    step(); step();
    t_in[K_START_BIT] = 1'b0; t_in[3] = 1'b0;
    step();
    expect_now("start_beats_digit", vec(16'h0005, 1, 1, 1, 0, 1));
    press_t(K_CANCEL_BIT); press_t(K_CANCEL_BIT);

    // Fifth digit ignored; start on 0000 ignored.
    press_t(1); press_t(2); press_t(3); press_t(4); press_t(5);
    expect_now("fifth_digit_ignored", vec(16'h4321, 0, 0, 0, 0, 0));
    press_t(K_CANCEL_BIT);
    press_t(0);
    press_t(K_START_BIT);
    expect_now("start_on_zero_ignored", vec(16'h0000, 0, 0, 0, 0, 0));
    press_t(K_CANCEL_BIT);

    // Door opening on the tick that would reach 0000: door wins, holds 0001.
    press_t(1);
    press_t(K_START_BIT);
    wait_cycles(HZ - 2);
    porta_in = 1'b1; step();
    expect_now("door_beats_last_tick", vec(16'h0001, 1, 0, 0, 0, 1));
    porta_in = 1'b0; step();
    press_t(K_START_BIT);
    wait_cycles(HZ - 1);
    expect_now("done_from_0001", vec(16'h0000, 0, 0, 0, 1, 1));
    press_t(K_CANCEL_BIT);
    expect_now("cancel_in_done", vec(16'h0000, 0, 0, 0, 0, 0));

    // Cancel coinciding with a tick: decrement skipped.
    press_t(2);
    press_t(K_START_BIT);
    wait_cycles(HZ - 3);
    t_in[K_CANCEL_BIT] = 1'b1; step(); step();
    expect_now("cancel_beats_tick", vec(16'h0002, 0, 0, 0, 0, 1));
    t_in[K_CANCEL_BIT] = 1'b0; step();
    press_t(K_CANCEL_BIT);

    // Reset mid-cook clears outputs and slots.
    press_t(5);
    press_t(K_START_BIT);
    wait_cycles(3);
    rst_in = 1'b1; step();
    expect_now("reset_mid_cook", vec(16'h0000, 0, 0, 0, 0, 0));
    rst_in = 1'b0;
    press_r(2);
    expect_now("slot2_cleared_by_reset", vec(16'h0000, 0, 0, 0, 0, 0));
    press_t(K_CANCEL_BIT);

    // Randomised phase, checked cycle by cycle against the model.
    for (int a = 0; a < 300; a++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        rst_in = 1'b1; step(); rst_in = 1'b0;
      end else if (sel < 14) begin
        porta_in = ~porta_in; step();
      end else begin
        kind = $urandom_range(0, 9);
        if (kind == 0)      t_in[K_CANCEL_BIT] = 1'b1;
        else if (kind <= 3) t_in[K_START_BIT] = 1'b1;
        else if (kind == 4) conf_in = 1'b1;
        else if (kind == 5) r_in[$urandom_range(0, 3)] = 1'b1;
        else t_in[($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 9)] = 1'b1;
        if ($urandom_range(0, 7) == 0) begin
          extra = $urandom_range(0, 16);
          if (extra < 12)       t_in[extra] = 1'b1;
          else if (extra == 12) conf_in = 1'b1;
          else                  r_in[extra - 13] = 1'b1;
        end
        repeat ($urandom_range(1, 3)) step();
        t_in = '0; conf_in = 1'b0; r_in = '0;
        step();
      end
      repeat ($urandom_range(0, 12)) step();
      if ($urandom_range(0, 9) == 0) repeat (HZ * $urandom_range(1, 4)) step();
    end

    // Drain: every queued expectation must have been consumed.
    porta_in = 1'b0;
    step(); step();
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (cyc_q.size() == 0 && dir_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d expectations left, want 0/0",
                  cyc_q.size(), dir_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
